uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter. It generalises the fixed 8N1 one-bit-per-clock serializer with:
- an internal baud divider
- configurable data width, parity and stop bits
- a ready/valid input handshake with back-to-back frame support

It sits between a byte source (FIFO or register interface) and the serial tx pin, and pairs with the team's UART receiver.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal >= 2
DATA_BITS, 8, data bits per frame; legal 5..9
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits; legal 1 or 2

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
data_in  input  DATA_BITS  word to transmit
data_valid  input  1  data_in is valid
data_ready  output  1  block can accept a word this cycle
tx  output  1  serial line, idle high
busy  output  1  high while a frame is in progress
tx_done  output  1  one-cycle pulse on the final cycle of the last stop bit

Behaviour:
- Reset (reset_n=0, asynchronous): tx=1, busy=0, tx_done=0, data_ready=1, state IDLE, all counters 0. This takes effect immediately, including mid-frame: the frame is abandoned and the line returns high without waiting for a clock edge.
- States: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY_EN=0.
- Baud counter: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). bit_end = (count == CLKS_PER_BIT-1). It resets to 0 on every state entry.
- Handshake: a word is accepted on a rising edge where data_valid && data_ready.
  - data_ready=1 in IDLE.
  - data_ready=1 on the final cycle of the last stop bit (bit_end in STOP, last stop bit).
  - data_ready=0 otherwise.
- On acceptance:
  - data_in is latched into a shift register and parity is computed from the latched value.
  - tx is registered to 0 and the state becomes START.
  - tx is therefore low from the cycle after the handshake.
  - data_in changes after acceptance have no effect on the frame.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: bits are sent LSB first, each held CLKS_PER_BIT cycles. The bit counter has width $clog2(DATA_BITS). After bit DATA_BITS-1 the next state is PARITY (if PARITY_EN) or STOP.
- PARITY: tx = ^data (even) or ~^data (odd) for CLKS_PER_BIT cycles, then STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle:
  - tx_done=1.
  - If a handshake occurs on that edge: go directly to START with no idle gap, and busy stays 1.
  - Otherwise go to IDLE with busy=0.
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, measured from the first tx-low cycle to the last stop cycle inclusive.
- busy: 1 in every state except IDLE.
- tx is registered. No combinational path exists from any input to tx.
- data_valid held high while data_ready=0 causes no state change. The word waits and is not dropped.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - constant FRAME_BITS function
  - parameter-legality checks (elaboration-time $error on illegal DATA_BITS, STOP_BITS, CLKS_PER_BIT)
- Sub-module uart_baud_gen (parameter CLKS_PER_BIT; ports clk, reset_n, clear, bit_end). It is a natural split and is reusable by the receiver, with a mid-bit sample variant added later.
- Top module contains the FSM, shift register, bit counter and parity.

Test Plan:
- CLKS_PER_BIT=4, 8N1, data_in=0xA5 with 1-cycle valid -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total); tx_done pulses on cycle 40; busy high for 40 cycles; data_ready low during the frame except on cycle 40.
- PARITY_EN=1, 0xA5 (four ones) -> parity bit 0 when PARITY_ODD=0, 1 when PARITY_ODD=1; frame length 44 cycles at CLKS_PER_BIT=4.
- Back-to-back: data_valid held high with 0x3C then 0xC3 -> second start bit begins on the cycle immediately after the first stop bit; no idle-high gap; busy never drops; two tx_done pulses 40 cycles apart.
- DATA_BITS=7, STOP_BITS=2, 0x55 -> 0, 1,0,1,0,1,0,1, 1,1; 10 bits x CLKS_PER_BIT cycles.
- reset_n asserted low mid-DATA (bit 3) -> tx=1 and busy=0 immediately, before the next edge. After release: data_ready=1 and no residual tx_done; a new frame sends correctly.
- data_in changed to 0xFF one cycle after accepting 0x00 -> all eight data bits are transmitted as 0.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks: the transmitter state encoding,
// a helper that gives the number of serial bit slots in one frame, and a
// parameter legality check used at elaboration time by the modules.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  // Bit slots in one frame: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int dataBits, input int parityEn,
                                    input int stopBits);
    return 1 + dataBits + parityEn + stopBits;
  endfunction

  // True when every parameter lies inside the range the transmitter supports.
  function automatic bit cfg_legal(input int clksPerBit, input int dataBits,
                                   input int parityEn, input int parityOdd,
                                   input int stopBits);
    return (clksPerBit >= 2) &&
           (dataBits >= 5) && (dataBits <= 9) &&
           (parityEn == 0 || parityEn == 1) &&
           (parityOdd == 0 || parityOdd == 1) &&
           (stopBits == 1 || stopBits == 2);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the
// last clock of each bit period. Holding clear returns the count to zero so
// the owner can align bit periods to state entry.
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   clear    in   hold the counter at zero
//   bit_end  out  high on the final clock of the current bit period
// ---------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign bit_end = (count_q == LAST_COUNT);

  // Wrap explicitly at the end of a bit so non power-of-two periods work;
  // the wrap also lands the count on zero whenever the FSM changes state.
  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || bit_end) begin
      count_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional even/odd parity, one or two stop bits. Words are taken through a
// ready/valid handshake; a word offered on the last stop cycle starts the
// next frame with no idle gap.
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   data_in     in   word to transmit
//   data_valid  in   data_in is valid
//   data_ready  out  a word is accepted on this edge if data_valid is high
//   tx          out  registered serial line, idle high
//   busy        out  a frame is in progress
//   tx_done     out  pulse on the final cycle of the last stop bit
// ---------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  import uart_pkg::*;

  if (!cfg_legal(CLKS_PER_BIT, DATA_BITS, PARITY_EN, PARITY_ODD, STOP_BITS)) begin : gBadCfg
    $error("uart_tx_frame: illegal parameter set");
  end

  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BCW-1:0]       bitCnt_q, bitCnt_d;
  logic                 stopCnt_q, stopCnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 bitEnd;
  logic                 frameEnd;
  logic                 accept;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uBaud (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (state_q == IDLE),
    .bit_end(bitEnd)
  );

  assign frameEnd = (state_q == STOP) && bitEnd && (stopCnt_q == LAST_STOP);
  assign accept   = data_valid && data_ready;

  // State and datapath registers; reset forces the line high at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      stopCnt_q <= 1'b0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitCnt_q  <= bitCnt_d;
      stopCnt_q <= stopCnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

  // Next state and datapath. An accepted word overrides whatever the current
  // state would do, which is how the last stop cycle chains into a new start.
  // The next tx level is derived from the next state so tx stays registered.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitCnt_d  = bitCnt_q;
    stopCnt_d = stopCnt_q;
    parity_d  = parity_q;
    tx_d      = 1'b1;

    case (state_q)
      IDLE: begin
      end
      START: begin
        if (bitEnd) state_d = DATA;
      end
      DATA: begin
        if (bitEnd) begin
          if (bitCnt_q == LAST_BIT) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
            shift_d  = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bitEnd) state_d = STOP;
      end
      STOP: begin
        if (bitEnd) begin
          if (stopCnt_q == LAST_STOP) begin
            state_d = IDLE;
          end else begin
            stopCnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d   = START;
      shift_d   = data_in;
      bitCnt_d  = '0;
      stopCnt_d = 1'b0;
      parity_d  = (^data_in) ^ (PARITY_ODD != 0);
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  // Handshake and status outputs.
  always_comb begin
    data_ready = (state_q == IDLE) || frameEnd;
    busy       = (state_q != IDLE);
    tx_done    = frameEnd;
    tx         = tx_q;
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
// Four transmitter configurations side by side. Each scenario builds the
// expected per-cycle {tx,busy,tx_done,data_ready} stream from the frame
// format (start, data LSB first, parity, stop bits) and compares it with
// what the selected instance produced.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [8:0] dataIn [4];
  logic [3:0] validIn;
  logic [3:0] txV, busyV, doneV, readyV;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // 8N1
  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .data_in(dataIn[0][7:0]), .data_valid(validIn[0]),
    .data_ready(readyV[0]), .tx(txV[0]), .busy(busyV[0]), .tx_done(doneV[0]));
  // 8E1
  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .data_in(dataIn[1][7:0]), .data_valid(validIn[1]),
    .data_ready(readyV[1]), .tx(txV[1]), .busy(busyV[1]), .tx_done(doneV[1]));
  // 7N2, three clocks per bit
  uart_tx_frame #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .data_in(dataIn[2][6:0]), .data_valid(validIn[2]),
    .data_ready(readyV[2]), .tx(txV[2]), .busy(busyV[2]), .tx_done(doneV[2]));
  // 8O1
  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut3 (
    .clk(clk), .reset_n(reset_n), .data_in(dataIn[3][7:0]), .data_valid(validIn[3]),
    .data_ready(readyV[3]), .tx(txV[3]), .busy(busyV[3]), .tx_done(doneV[3]));

  // Configuration of each instance, mirrored from the instantiations above.
  function automatic void cfgOf(input int inst, output int cpb, output int db,
                                output int pe, output int po, output int sb);
    case (inst)
      0:       begin cpb = 4; db = 8; pe = 0; po = 0; sb = 1; end
      1:       begin cpb = 4; db = 8; pe = 1; po = 0; sb = 1; end
      2:       begin cpb = 3; db = 7; pe = 0; po = 0; sb = 2; end
      default: begin cpb = 4; db = 8; pe = 1; po = 1; sb = 1; end
    endcase
  endfunction

  // Reference: one idle cycle, then each frame's bit slots stretched to
  // cpb cycles, tx_done/data_ready on the final stop cycle, then idle again.
  task automatic modelChain(input int inst, input logic [8:0] words[$],
                            output logic [3:0] exp[$]);
    int cpb, db, pe, po, sb, total, ones;
    bit bits[$];
    cfgOf(inst, cpb, db, pe, po, sb);
    exp = {};
    exp.push_back(4'b1001);
    foreach (words[k]) begin
      bits = {};
      bits.push_back(1'b0);
      for (int i = 0; i < db; i++) bits.push_back(words[k][i]);
      ones = $countones(words[k] & 9'((1 << db) - 1));
      if (pe != 0) bits.push_back(((ones % 2) != 0) ^ (po != 0));
      for (int i = 0; i < sb; i++) bits.push_back(1'b1);
      total = bits.size() * cpb;
      for (int c = 0; c < total; c++)
        exp.push_back({bits[c / cpb], 1'b1, c == total - 1, c == total - 1});
    end
    exp.push_back(4'b1001);
  endtask

  // Drives a chain of words with valid held high and records one sample per
  // cycle at the falling edge. The data lines take lateWord once the chain
  // is exhausted, to show a post-handshake change has no effect.
  task automatic applyStimulus(input int inst, input logic [8:0] words[$],
                               input logic [8:0] lateWord, input int nCycles,
                               output logic [3:0] got[$]);
    int idx;
    bit pending;
    got = {};
    @(negedge clk);
    dataIn[inst]  = words[0];
    validIn[inst] = 1'b1;
    idx = 1;
    for (int c = 0; c <= nCycles; c++) begin
      pending = validIn[inst] && readyV[inst];
      got.push_back({txV[inst], busyV[inst], doneV[inst], readyV[inst]});
      if (c == nCycles) break;
      @(negedge clk);
      if (pending) begin
        if (idx < words.size()) begin
          dataIn[inst] = words[idx];
          idx++;
        end else begin
          validIn[inst] = 1'b0;
          dataIn[inst]  = lateWord;
        end
      end
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({txV[i], busyV[i], doneV[i], readyV[i]} !== 4'b1001) begin
        miscompares++;
        $display("[TB] FAIL reset inst%0d {tx,busy,done,ready} got %b exp 1001", i,
                 {txV[i], busyV[i], doneV[i], readyV[i]});
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic_8n1();
    logic [3:0] exp[$], got[$];
    int nb;
    modelChain(0, '{9'h0A5}, exp);
    applyStimulus(0, '{9'h0A5}, 9'h05A, exp.size() - 1, got);
    for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL 8n1 cyc%0d {tx,busy,done,ready} got %b exp %b", i, got[i], exp[i]);
      end
    end
    nb = 0;
    foreach (got[i]) if (got[i][2]) nb++;
    vectors++;
    if (nb !== 40) begin
      miscompares++;
      $display("[TB] FAIL 8n1_busy_cycles got %0d exp 40", nb);
    end
  endtask

  task automatic test_parity();
    logic [3:0] exp[$], got[$];
    for (int inst = 1; inst <= 3; inst += 2) begin
      modelChain(inst, '{9'h0A5}, exp);
      applyStimulus(inst, '{9'h0A5}, 9'h000, exp.size() - 1, got);
      for (int i = 0; i < exp.size(); i++) begin
        vectors++;
        if (got[i] !== exp[i]) begin
          miscompares++;
          $display("[TB] FAIL parity inst%0d cyc%0d {tx,busy,done,ready} got %b exp %b",
                   inst, i, got[i], exp[i]);
        end
      end
      // Parity slot covers cycles 37..40 of a 44-cycle frame.
      vectors++;
      if (got[37][3] !== (inst == 3)) begin
        miscompares++;
        $display("[TB] FAIL parity_bit inst%0d got %b exp %b", inst, got[37][3], inst == 3);
      end
      vectors++;
      if (got.size() !== 46 || got[44] !== 4'b1111 || got[45] !== 4'b1001) begin
        miscompares++;
        $display("[TB] FAIL parity_len inst%0d got size %0d end %b exp size 46 end 1111", inst,
                 got.size(), got[44]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp[$], got[$];
    int doneAt[$];
    modelChain(0, '{9'h03C, 9'h0C3}, exp);
    applyStimulus(0, '{9'h03C, 9'h0C3}, 9'h1FF, exp.size() - 1, got);
    for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL b2b cyc%0d {tx,busy,done,ready} got %b exp %b", i, got[i], exp[i]);
      end
    end
    foreach (got[i]) if (got[i][1]) doneAt.push_back(i);
    vectors++;
    if (doneAt.size() !== 2 || doneAt[1] - doneAt[0] !== 40) begin
      miscompares++;
      $display("[TB] FAIL b2b_done_spacing got %0d pulses exp 2 pulses 40 apart", doneAt.size());
    end
  endtask

  task automatic test_7n2();
    logic [3:0] exp[$], got[$];
    int nb;
    modelChain(2, '{9'h055}, exp);
    applyStimulus(2, '{9'h055}, 9'h02A, exp.size() - 1, got);
    for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL 7n2 cyc%0d {tx,busy,done,ready} got %b exp %b", i, got[i], exp[i]);
      end
    end
    nb = 0;
    foreach (got[i]) if (got[i][2]) nb++;
    vectors++;
    if (nb !== 30) begin
      miscompares++;
      $display("[TB] FAIL 7n2_busy_cycles got %0d exp 30", nb);
    end
  endtask

  task automatic test_data_change();
    logic [3:0] exp[$], got[$];
    int ones;
    modelChain(0, '{9'h000}, exp);
    applyStimulus(0, '{9'h000}, 9'h0FF, exp.size() - 1, got);
    for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL data_change cyc%0d {tx,busy,done,ready} got %b exp %b", i, got[i], exp[i]);
      end
    end
    ones = 0;
    for (int i = 5; i <= 36; i++) if (got[i][3] !== 1'b0) ones++;
    vectors++;
    if (ones !== 0) begin
      miscompares++;
      $display("[TB] FAIL data_change_bits got %0d high data cycles exp 0", ones);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] exp[$], got[$];
    @(negedge clk);
    dataIn[0]  = 9'h0A5;
    validIn[0] = 1'b1;
    @(negedge clk);
    validIn[0] = 1'b0;
    repeat (17) @(negedge clk);
    vectors++;
    if (txV[0] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_bit3 tx got %b exp 0", txV[0]);
    end
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if ({txV[0], busyV[0], doneV[0], readyV[0]} !== 4'b1001) begin
      miscompares++;
      $display("[TB] FAIL midreset_async got %b exp 1001", {txV[0], busyV[0], doneV[0], readyV[0]});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({txV[0], busyV[0], doneV[0], readyV[0]} !== 4'b1001) begin
      miscompares++;
      $display("[TB] FAIL midreset_release got %b exp 1001", {txV[0], busyV[0], doneV[0], readyV[0]});
    end
    modelChain(0, '{9'h05A}, exp);
    applyStimulus(0, '{9'h05A}, 9'h0A5, exp.size() - 1, got);
    for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL midreset_refill cyc%0d got %b exp %b", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] exp[$], got[$];
    logic [8:0] words[$];
    logic [8:0] late;
    int cpb, db, pe, po, sb, n;
    for (int r = 0; r < 6; r++) begin
      for (int inst = 0; inst < 4; inst++) begin
        cfgOf(inst, cpb, db, pe, po, sb);
        n = $urandom_range(1, 3);
        words = {};
        for (int k = 0; k < n; k++) words.push_back(9'($urandom_range(0, (1 << db) - 1)));
        late = 9'($urandom_range(0, (1 << db) - 1));
        modelChain(inst, words, exp);
        applyStimulus(inst, words, late, exp.size() - 1, got);
        for (int i = 0; i < exp.size(); i++) begin
          vectors++;
          if (got[i] !== exp[i]) begin
            miscompares++;
            $display("[TB] FAIL random r%0d inst%0d cyc%0d got %b exp %b", r, inst, i, got[i], exp[i]);
          end
        end
      end
    end
  endtask

  initial begin
    validIn = '0;
    for (int i = 0; i < 4; i++) dataIn[i] = '0;
    test_reset();
    test_basic_8n1();
    test_parity();
    test_back_to_back();
    test_7n2();
    test_data_change();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
